// File: rtl/cv_pkg.sv
// Shared definitions for the convolution tile scheduler: default widths and
// the FSM state encoding.
package cv_pkg;

    localparam int CV_DW = 11;
    localparam int CV_CW = 16;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SETUP   = 4'd1;
    localparam logic [3:0] ST_ISS_LW  = 4'd2;
    localparam logic [3:0] ST_WT_LW   = 4'd3;
    localparam logic [3:0] ST_ISS_LIF = 4'd4;
    localparam logic [3:0] ST_WT_LIF  = 4'd5;
    localparam logic [3:0] ST_ISS_SOF = 4'd6;
    localparam logic [3:0] ST_WT_SOF  = 4'd7;
    localparam logic [3:0] ST_NEXT    = 4'd8;
    localparam logic [3:0] ST_FIN     = 4'd9;

    typedef enum logic [3:0] {
        IDLE    = ST_IDLE,
        SETUP   = ST_SETUP,
        ISS_LW  = ST_ISS_LW,
        WT_LW   = ST_WT_LW,
        ISS_LIF = ST_ISS_LIF,
        WT_LIF  = ST_WT_LIF,
        ISS_SOF = ST_ISS_SOF,
        WT_SOF  = ST_WT_SOF,
        NEXT    = ST_NEXT,
        FIN     = ST_FIN
    } state_t;

endpackage

// File: rtl/cv_tile_iter.sv
// One axis of the tile loop: origin counter with step/limit, clipped extent
// (plus halo padding) and a wrap flag that carries into the next outer axis.
import cv_pkg::*;

module cv_tile_iter #(
    parameter int DW = CV_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          adv,
    input  logic [DW-1:0] step,
    input  logic [DW-1:0] limit,
    input  logic [DW-1:0] pad,
    output logic [DW-1:0] ori,
    output logic [DW-1:0] ext,
    output logic          wrap
);

    logic [DW:0]   sum;
    logic [DW-1:0] nxt_ori;
    logic [DW-1:0] remain;
    logic [DW-1:0] clip;

    // Next origin and its edge-clipped extent; the sum is one bit wider so a
    // step past the top of the range is still seen as a wrap.
    always_comb begin
        sum     = {1'b0, ori} + {1'b0, step};
        wrap    = (sum >= {1'b0, limit});
        nxt_ori = (clear || wrap) ? '0 : sum[DW-1:0];
        remain  = limit - nxt_ori;
        clip    = (step < remain) ? step : remain;
    end

    // Origin and extent move together so the loader always sees a coherent tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ori <= '0;
            ext <= '0;
        end else if (clear || adv) begin
            ori <= nxt_ori;
            ext <= clip + pad;
        end
    end

endmodule

// File: rtl/cv_tile_scheduler.sv
// Convolution tile scheduler: walks (o, h, w) tiles of a layer and drives the
// loader through load-weight / load-input / store-output per tile.
// Optional macro CV_SCHED_WEIGHT_REUSE_EN: skip the weight load when a tile
// keeps the previous tile's output-channel origin within the same layer.
import cv_pkg::*;

module cv_tile_scheduler #(
    parameter int DW = CV_DW,
    parameter int CW = CV_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] I,
    input  logic [DW-1:0] O,
    input  logic [DW-1:0] H,
    input  logic [DW-1:0] W,
    input  logic [4:0]    K,
    input  logic [DW-1:0] TO,
    input  logic [DW-1:0] TH,
    input  logic [DW-1:0] TW,
    input  logic          core_idle,
    input  logic          ld_done,
    output logic          load_weight,
    output logic          load_input,
    output logic          store_output,
    output logic [DW-1:0] Iori,
    output logic [DW-1:0] Oori,
    output logic [DW-1:0] Hori,
    output logic [DW-1:0] Wori,
    output logic [DW-1:0] Iext,
    output logic [DW-1:0] Oext,
    output logic [DW-1:0] Hext,
    output logic [DW-1:0] Wext,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] tile_cnt
);

    state_t state, state_nxt;

    logic [DW-1:0] o_q, h_q, w_q, to_q, th_q, tw_q;
    logic [4:0]    k_q;
    logic [DW-1:0] kx_q, kx_in;
    logic          accept;
    logic          illegal;
    logic          skip_lw;
    logic          o_wrap, h_wrap, w_wrap, all_wrap;
    logic          adv_o, adv_h, adv_w;
    logic [DW-1:0] o_step, o_lim, h_step, h_lim, w_step, w_lim, hw_pad;

    assign accept   = (state == IDLE) && start;
    assign kx_q     = {{(DW-5){1'b0}}, k_q};
    assign kx_in    = {{(DW-5){1'b0}}, K};
    assign illegal  = (k_q == 5'd0) || (kx_q > h_q) || (kx_q > w_q) ||
                      (to_q == '0) || (th_q == '0) || (tw_q == '0) ||
                      (o_q == '0) || (Iext == '0);
    assign all_wrap = o_wrap && h_wrap && w_wrap;
    assign adv_w    = (state == NEXT) && !all_wrap;
    assign adv_h    = adv_w && w_wrap;
    assign adv_o    = adv_h && h_wrap;
    assign Iori     = '0;

    // Iterators take the raw shape while the first tile is being primed at start,
    // and the latched shape for every later step.
    always_comb begin
        if (state == IDLE) begin
            o_step = TO;
            o_lim  = O;
            h_step = TH;
            h_lim  = H - kx_in + DW'(1);
            w_step = TW;
            w_lim  = W - kx_in + DW'(1);
            hw_pad = kx_in - DW'(1);
        end else begin
            o_step = to_q;
            o_lim  = o_q;
            h_step = th_q;
            h_lim  = h_q - kx_q + DW'(1);
            w_step = tw_q;
            w_lim  = w_q - kx_q + DW'(1);
            hw_pad = kx_q - DW'(1);
        end
    end

    cv_tile_iter #(.DW(DW)) u_iter_o (
        .clk(clk), .rst_n(rst_n), .clear(accept), .adv(adv_o),
        .step(o_step), .limit(o_lim), .pad('0),
        .ori(Oori), .ext(Oext), .wrap(o_wrap)
    );

    cv_tile_iter #(.DW(DW)) u_iter_h (
        .clk(clk), .rst_n(rst_n), .clear(accept), .adv(adv_h),
        .step(h_step), .limit(h_lim), .pad(hw_pad),
        .ori(Hori), .ext(Hext), .wrap(h_wrap)
    );

    cv_tile_iter #(.DW(DW)) u_iter_w (
        .clk(clk), .rst_n(rst_n), .clear(accept), .adv(adv_w),
        .step(w_step), .limit(w_lim), .pad(hw_pad),
        .ori(Wori), .ext(Wext), .wrap(w_wrap)
    );

`ifdef CV_SCHED_WEIGHT_REUSE_EN
    logic wt_valid;

    // Weights stay valid until the output-channel origin moves or a new layer starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_valid <= 1'b0;
        end else if (accept || adv_o) begin
            wt_valid <= 1'b0;
        end else if ((state == WT_LW) && ld_done) begin
            wt_valid <= 1'b1;
        end
    end

    assign skip_lw = wt_valid;
`else
    assign skip_lw = 1'b0;
`endif

    // Layer shape is captured once per accepted start; later starts are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q  <= '0;
            h_q  <= '0;
            w_q  <= '0;
            k_q  <= '0;
            to_q <= '0;
            th_q <= '0;
            tw_q <= '0;
            Iext <= '0;
        end else if (accept) begin
            o_q  <= O;
            h_q  <= H;
            w_q  <= W;
            k_q  <= K;
            to_q <= TO;
            th_q <= TH;
            tw_q <= TW;
            Iext <= I;
        end
    end

    // Tile counter and sticky shape error, both cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            tile_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if ((state == NEXT) && (tile_cnt != '1)) begin
                tile_cnt <= tile_cnt + CW'(1);
            end
            if ((state == SETUP) && illegal) begin
                err <= 1'b1;
            end
        end
    end

    // State register; reset pulls commands low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and command/status decode.
    always_comb begin
        state_nxt    = state;
        load_weight  = 1'b0;
        load_input   = 1'b0;
        store_output = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SETUP;
            end
            SETUP: begin
                busy = 1'b1;
                if (illegal)      state_nxt = FIN;
                else if (skip_lw) state_nxt = ISS_LIF;
                else              state_nxt = ISS_LW;
            end
            ISS_LW: begin
                busy        = 1'b1;
                load_weight = 1'b1;
                if (core_idle) state_nxt = WT_LW;
            end
            WT_LW: begin
                busy = 1'b1;
                if (ld_done) state_nxt = ISS_LIF;
            end
            ISS_LIF: begin
                busy       = 1'b1;
                load_input = 1'b1;
                if (core_idle) state_nxt = WT_LIF;
            end
            WT_LIF: begin
                busy = 1'b1;
                if (ld_done) state_nxt = ISS_SOF;
            end
            ISS_SOF: begin
                busy         = 1'b1;
                store_output = 1'b1;
                if (core_idle) state_nxt = WT_SOF;
            end
            WT_SOF: begin
                busy = 1'b1;
                if (ld_done) state_nxt = NEXT;
            end
            NEXT: begin
                busy      = 1'b1;
                state_nxt = all_wrap ? FIN : SETUP;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cv_tile_scheduler.sv
// Self-checking bench for cv_tile_scheduler: a loader model answers commands,
// and a nested-loop reference model predicts every accepted command.
// Honours CV_SCHED_WEIGHT_REUSE_EN when building the expected command stream.
module tb_cv_tile_scheduler;

    localparam int DW = 11;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] I = '0, O = '0, H = '0, W = '0, TO = '0, TH = '0, TW = '0;
    logic [4:0]    K = '0;
    logic          core_idle = 1'b0;
    logic          ld_done = 1'b0;
    logic          load_weight, load_input, store_output;
    logic [DW-1:0] Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext;
    logic          busy, done, err;
    logic [CW-1:0] tile_cnt;

    int total = 0;
    int bad = 0;
    logic [127:0] exp_q[$];

    cv_tile_scheduler #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .I(I), .O(O), .H(H), .W(W), .K(K), .TO(TO), .TH(TH), .TW(TW),
        .core_idle(core_idle), .ld_done(ld_done),
        .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
        .Iori(Iori), .Oori(Oori), .Hori(Hori), .Wori(Wori),
        .Iext(Iext), .Oext(Oext), .Hext(Hext), .Wext(Wext),
        .busy(busy), .done(done), .err(err), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [127:0] packCmd(input logic [2:0] typ, input int cnt, input int oo,
                                             input int hh, input int ww, input int ie,
                                             input int oe, input int he, input int we);
        logic [127:0] r;
        r = '0;
        r[106:0] = {typ, 16'(cnt), 11'(0), 11'(oo), 11'(hh), 11'(ww),
                    11'(ie), 11'(oe), 11'(he), 11'(we)};
        return r;
    endfunction

    function automatic logic [127:0] observed();
        logic [127:0] r;
        r = '0;
        r[106:0] = {load_weight, load_input, store_output, tile_cnt, Iori, Oori, Hori, Wori,
                    Iext, Oext, Hext, Wext};
        return r;
    endfunction

    function automatic logic [127:0] allOuts();
        logic [127:0] r;
        r = '0;
        r[109:0] = {load_weight, load_input, store_output, busy, done, err, tile_cnt,
                    Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext};
        return r;
    endfunction

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: plain nested loops over output coordinates.
    task automatic buildModel(input int i_, input int o_, input int h_, input int w_, input int k_,
                              input int to_, input int th_, input int tw_,
                              output int tiles, output bit illegal);
        int  hout, wout, prev_o, oe, he, we;
        bit  lw;
        exp_q.delete();
        tiles   = 0;
        illegal = (k_ == 0) || (k_ > h_) || (k_ > w_) || (to_ == 0) || (th_ == 0) ||
                  (tw_ == 0) || (o_ == 0) || (i_ == 0);
        if (!illegal) begin
            hout   = h_ - k_ + 1;
            wout   = w_ - k_ + 1;
            prev_o = -1;
            for (int oo = 0; oo < o_; oo += to_) begin
                for (int hh = 0; hh < hout; hh += th_) begin
                    for (int ww = 0; ww < wout; ww += tw_) begin
                        oe = minInt(to_, o_ - oo);
                        he = minInt(th_, hout - hh) + k_ - 1;
                        we = minInt(tw_, wout - ww) + k_ - 1;
                        lw = 1'b1;
`ifdef CV_SCHED_WEIGHT_REUSE_EN
                        lw = (oo != prev_o);
`endif
                        if (lw) exp_q.push_back(packCmd(3'b100, tiles, oo, hh, ww, i_, oe, he, we));
                        exp_q.push_back(packCmd(3'b010, tiles, oo, hh, ww, i_, oe, he, we));
                        exp_q.push_back(packCmd(3'b001, tiles, oo, hh, ww, i_, oe, he, we));
                        prev_o = oo;
                        tiles++;
                    end
                end
            end
        end
    endtask

    // mode 0: core always idle, ld_done 3 cycles after accept
    // mode 1: random core_idle/latency plus mid-layer start and stray ld_done
    // mode 2: hold core_idle low for 10 cycles on the first command
    // abort_sof > 0: pull reset while waiting on that store-output
    task automatic applyStimulus(input int i_, input int o_, input int h_, input int w_, input int k_,
                                 input int to_, input int th_, input int tw_,
                                 input int mode, input int abort_sof);
        int           tiles, budget, cyc, cnt, stall_left, hi_cnt, sof_n;
        bit           illegal, finished, lbusy, stall_checked, abort_now;
        logic [127:0] expv;
        buildModel(i_, o_, h_, w_, k_, to_, th_, tw_, tiles, illegal);
        budget = 100 + exp_q.size() * 30;
        @(negedge clk);
        I = DW'(i_); O = DW'(o_); H = DW'(h_); W = DW'(w_); K = 5'(k_);
        TO = DW'(to_); TH = DW'(th_); TW = DW'(tw_);
        start = 1'b1;
        core_idle = 1'b1;
        finished = 0; cyc = 0; lbusy = 0; cnt = 0; hi_cnt = 0; sof_n = 0;
        stall_left = (mode == 2) ? 10 : 0;
        stall_checked = (mode != 2);
        abort_now = 0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            ld_done = 1'b0;
            if (cyc == 1) checkOutput("start_state", {err, busy}, 2'b01);
            if (done) begin
                checkOutput("done_busy", busy, 0);
                checkOutput("err", err, illegal);
                if (illegal) checkOutput("err_latency", (cyc <= 3), 1);
                checkOutput("tile_cnt", tile_cnt, tiles);
                checkOutput("cmds_left", exp_q.size(), 0);
                @(negedge clk);
                checkOutput("done_pulse", {done, busy}, 0);
                finished = 1;
            end else if (lbusy) begin
                if ({load_weight, load_input, store_output} != 3'b000)
                    checkOutput("cmd_in_wait", {load_weight, load_input, store_output}, 0);
                if (abort_now) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("reset_outs", allOuts(), 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    lbusy = 0;
                    finished = 1;
                end else begin
                    cnt--;
                    if (cnt == 0) begin
                        ld_done = 1'b1;
                        lbusy = 0;
                    end
                end
            end else if ({load_weight, load_input, store_output} != 3'b000) begin
                if (!stall_checked) begin
                    hi_cnt++;
                    if (stall_left > 0) begin
                        core_idle = 1'b0;
                        stall_left--;
                    end else begin
                        core_idle = 1'b1;
                        checkOutput("stall_hold", hi_cnt, 11);
                        stall_checked = 1;
                    end
                end else if (mode == 1) begin
                    core_idle = ($urandom_range(0, 3) != 0);
                    if (!core_idle && load_input && $urandom_range(0, 1) == 1) begin
                        start = 1'b1;
                        ld_done = 1'b1;
                        I = DW'($urandom_range(1, 2047)); O = DW'($urandom_range(1, 20));
                        H = DW'($urandom_range(3, 20)); W = DW'($urandom_range(3, 20));
                        K = 5'($urandom_range(1, 3)); TO = DW'($urandom_range(1, 7));
                        TH = DW'($urandom_range(1, 7)); TW = DW'($urandom_range(1, 7));
                    end
                end else begin
                    core_idle = 1'b1;
                end
                if (core_idle) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_cmd", observed(), 0);
                    end else begin
                        expv = exp_q.pop_front();
                        checkOutput("cmd", observed(), expv);
                    end
                    lbusy = 1;
                    cnt = (mode == 0) ? 3 : $urandom_range(1, 4);
                    if (store_output) begin
                        sof_n++;
                        if (sof_n == abort_sof) abort_now = 1;
                    end
                end
            end else begin
                core_idle = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        checkOutput("finished", finished, 1);
        start = 1'b0;
        ld_done = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        checkOutput("reset", allOuts(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] 8x10x10 layer, 4x4x4 tiles");
        applyStimulus(16, 8, 10, 10, 3, 4, 4, 4, 0, 0);
        $display("[TB] 7x7 layer with clipped edge tiles");
        applyStimulus(5, 1, 7, 7, 3, 1, 4, 4, 0, 0);
        $display("[TB] illegal shapes");
        applyStimulus(5, 4, 4, 10, 5, 2, 2, 2, 0, 0);
        applyStimulus(5, 4, 10, 10, 3, 0, 2, 2, 0, 0);
        applyStimulus(0, 4, 10, 10, 3, 2, 2, 2, 0, 0);
        applyStimulus(5, 4, 10, 10, 0, 2, 2, 2, 0, 0);
        $display("[TB] core busy stall on first command");
        applyStimulus(9, 2, 6, 6, 3, 1, 2, 2, 2, 0);
        $display("[TB] stray start and ld_done during a layer");
        applyStimulus(7, 3, 9, 8, 2, 2, 3, 3, 1, 0);
        $display("[TB] reset during store-output wait, then rerun");
        applyStimulus(16, 8, 10, 10, 3, 4, 4, 4, 0, 2);
        applyStimulus(16, 8, 10, 10, 3, 4, 4, 4, 0, 0);

        $display("[TB] random layers");
        for (int n = 0; n < 6; n++) begin
            applyStimulus($urandom_range(0, 2047), $urandom_range(1, 8),
                          $urandom_range(1, 10), $urandom_range(1, 10),
                          $urandom_range(1, 5), $urandom_range(0, 4),
                          $urandom_range(2, 5), $urandom_range(2, 5), 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv_tile_scheduler.md
Name: cv_tile_scheduler

Overview:
- Tiles a convolution layer into (output-channel, output-row, output-column) tiles and sequences the directly downstream data loader through load-weight / load-input / store-output commands for each tile.
- Per tile it drives the loader's origin/extent inputs (Iori/Oori/Hori/Wori, Iext/Oext/Hext/Wext) and waits on the loader's done pulse.
- Sits between the layer controller (start/layer shape) and the loader/core pair.

Parameters:
- DW, 11, width of all shape/origin/extent fields
- CW, 16, width of tile counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle layer start; ignored while busy
- I, O, H, W  in  DW each  layer input channels, output channels, input height, input width
- K  in  5  kernel size
- TO, TH, TW  in  DW each  tile size: output channels, output rows, output columns
- core_idle  in  1  core idle (same signal the loader sees)
- ld_done  in  1  loader done pulse
- load_weight, load_input, store_output  out  1 each  loader commands
- Iori, Oori, Hori, Wori  out  DW each  tile origins (output coordinates for H/W)
- Iext, Oext, Hext, Wext  out  DW each  tile extents (Hext/Wext in input rows/cols)
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse, layer finished
- err  out  1  sticky until next accepted start; illegal shape
- tile_cnt  out  CW  tiles completed this layer

Behaviour:
- Reset: all outputs 0, state IDLE.
- start in IDLE latches I, O, H, W, K, TO, TH, TW.
  - Computes Hout = H-K+1 and Wout = W-K+1, DW bits.
- Illegal shape: K=0, K>H, K>W, TO=0, TH=0, TW=0, O=0 or I=0.
  - Goes to FIN with err=1; no commands issued.
- Loop order: o outer, h middle, w inner. Origins start at 0.
  - Step: w += TW; on w ≥ Wout, w=0 and h += TH; on h ≥ Hout, h=0 and o += TO; on o ≥ O, layer complete.
- Extents with edge clipping:
  - Oext = min(TO, O-Oori)
  - Hext = min(TH, Hout-Hori)+K-1
  - Wext = min(TW, Wout-Wori)+K-1
  - Iori = 0 and Iext = I always.
- Origin/extent outputs are registered. They update only in NEXT and are stable from the cycle before any command until ld_done.
- States: IDLE → SETUP → ISS_LW → WT_LW → ISS_LIF → WT_LIF → ISS_SOF → WT_SOF → NEXT → (SETUP | FIN) → IDLE.
- Command handshake:
  - Each command is a combinational decode of state: load_weight = (state==ISS_LW), and likewise for the others.
  - ISS_x advances to WT_x in the same cycle core_idle=1. Accept condition is cmd && core_idle, matching the loader's own.
  - The command is therefore high for ≥1 cycle and never while the loader is back in idle after done.
- WT_x advances on ld_done. ld_done outside a WT state is ignored.
- NEXT increments tile_cnt (saturating at all-ones) and steps the counters.
- FIN: done=1 for one cycle, busy drops in the same cycle.
  - busy=1 from the cycle after an accepted start through FIN.
- Minimum latency from start to first command: 2 cycles (SETUP, then ISS_LW).
- start during busy: ignored, no effect on counters.
- rst_n low mid-layer: immediate return to IDLE, commands drop asynchronously. The loader must be reset alongside.

Optional Feature:
- Macro: CV_SCHED_WEIGHT_REUSE_EN
- Defined: when a tile's Oori equals the previous tile's Oori within the same layer, SETUP goes directly to ISS_LIF and the weight load is skipped. The first tile of the layer always loads weights.
- Undefined: every tile issues load_weight.

Decomposition:
- Shared package cv_pkg holds:
  - state enum for this FSM
  - DW default
  - localparams for state encoding
- Sub-module cv_tile_iter, instantiated three times (o/h/w): holds one origin counter with step, limit, clipped extent and wrap flag.
- The chained wrap flags form the nested loop.

Test Plan:
- O=8, TO=4, H=W=10, K=3, TH=TW=4, core_idle=1, ld_done 3 cycles after each accept → 8 tiles, 8 LIF, 8 SOF. LW count: 8 without macro, 2 with macro. Last tile Oori=4, Hori=4, Wori=4, Hext=Wext=6; done pulse; tile_cnt=8.
- H=W=7, K=3, TH=TW=4, O=TO=1 → tiles (Hori, Wori) in order (0,0), (0,4), (4,0), (4,4). Hext/Wext take values 6 and 3 per axis.
- K=5, H=4 → err=1 and done pulse within 3 cycles of start; no command ever asserted.
- Hold core_idle=0 for 10 cycles while in ISS_LW → load_weight stays high 10+1 cycles, state advances only when core_idle=1.
- start pulsed mid-layer plus spurious ld_done while in ISS_LIF → both ignored; tile sequence and tile_cnt unchanged.
- rst_n low during WT_SOF → all outputs 0 asynchronously; a fresh start then runs the full layer correctly.
